// File: rtl/romulus_tbc_ctrl_pkg.sv
// Shared definitions for the Romulus TBC sequencer: FSM states and the SKINNY round-constant LFSR.
package romulus_tbc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_CORR,
        ST_STEP
    } state_t;

    localparam int unsigned RC_W = 6;
    localparam logic [RC_W-1:0] RC_INIT = 6'h01;

    function automatic logic [RC_W-1:0] rc_next(input logic [RC_W-1:0] rc);
        return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
    endfunction

endpackage

// File: rtl/romulus_tbc_ctrl_rc_lfsr.sv
// Combinational unroll of the round-constant LFSR: one 6-bit slice per round handled this clock,
// most significant slice first, plus the register value for the next clock.
module romulus_tbc_ctrl_rc_lfsr
    import romulus_tbc_ctrl_pkg::*;
#(
    parameter int unsigned RNDS_PER_CLK = 1,
    parameter int unsigned CNTW         = 6
) (
    input  logic [CNTW-1:0]              rc,
    output logic [CNTW*RNDS_PER_CLK-1:0] constant,
    output logic [CNTW-1:0]              rc_adv
);

    if (CNTW != RC_W) begin : g_bad_cntw
        $error("romulus_tbc_ctrl_rc_lfsr: CNTW must be 6");
    end

    logic [RC_W-1:0] r;

    always_comb begin
        constant = '0;
        r        = rc;
        for (int unsigned i = 0; i < RNDS_PER_CLK; i++) begin
            constant[(RNDS_PER_CLK-1-i)*CNTW +: CNTW] = r;
            r = rc_next(r);
        end
        rc_adv = r;
    end

endmodule

// File: rtl/romulus_tbc_ctrl.sv
// Sequencer for the Romulus datapath: one SKINNY TBC invocation followed by a tweakey
// correction cycle, or a standalone counter LFSR step; Moore outputs from registered state.
module romulus_tbc_ctrl
    import romulus_tbc_ctrl_pkg::*;
#(
    parameter int unsigned RNDS         = 40,
    parameter int unsigned RNDS_PER_CLK = 1,
    parameter int unsigned CNTW         = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         cnt_step,
    output logic                         busy,
    output logic                         done,
    output logic                         sen,
    output logic                         senc,
    output logic                         xen,
    output logic                         xenc,
    output logic                         yen,
    output logic                         yenc,
    output logic                         zen,
    output logic                         zenc,
    output logic                         correct_cnt,
    output logic [CNTW*RNDS_PER_CLK-1:0] constant
);

    if (RNDS % RNDS_PER_CLK != 0) begin : g_bad_rpc
        $error("romulus_tbc_ctrl: RNDS must be a multiple of RNDS_PER_CLK");
    end

    localparam int unsigned NCYC = RNDS / RNDS_PER_CLK;
    localparam int unsigned CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NCYC - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   round_q;
    logic [CNTW-1:0] rc_q;
    logic [CNTW-1:0] rc_adv;
    logic            done_q;

    romulus_tbc_ctrl_rc_lfsr #(
        .RNDS_PER_CLK(RNDS_PER_CLK),
        .CNTW        (CNTW)
    ) u_rc_lfsr (
        .rc      (rc_q),
        .constant(constant),
        .rc_adv  (rc_adv)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end else if (cnt_step) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN:  if (round_q == LAST_CNT) state_d = ST_CORR;
            ST_CORR: state_d = ST_IDLE;
            ST_STEP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // rc is reloaded on the IDLE->RUN edge so the first RUN cycle always presents round 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            round_q <= '0;
            rc_q    <= RC_INIT;
            done_q  <= 1'b0;
        end else begin
            done_q <= (state_q == ST_CORR) || (state_q == ST_STEP);
            if (state_q == ST_RUN) begin
                round_q <= (round_q == LAST_CNT) ? '0 : round_q + 1'b1;
                rc_q    <= rc_adv;
            end else begin
                round_q <= '0;
                if (state_q == ST_IDLE && start) begin
                    rc_q <= RC_INIT;
                end
            end
        end
    end

    always_comb begin
        sen         = 1'b0;
        senc        = 1'b0;
        xen         = 1'b0;
        xenc        = 1'b0;
        yen         = 1'b0;
        yenc        = 1'b0;
        zen         = 1'b0;
        zenc        = 1'b0;
        correct_cnt = 1'b0;
        busy        = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                sen  = 1'b1;
                senc = 1'b1;
                xen  = 1'b1;
                xenc = 1'b1;
                yen  = 1'b1;
                yenc = 1'b1;
                zen  = 1'b1;
                zenc = 1'b1;
                busy = 1'b1;
            end
            ST_CORR: begin
                xen  = 1'b1;
                yen  = 1'b1;
                zen  = 1'b1;
                busy = 1'b1;
            end
            ST_STEP: begin
                zen         = 1'b1;
                correct_cnt = 1'b1;
                busy        = 1'b1;
            end
            default: ;
        endcase
    end

    assign done = done_q;

endmodule
